// File: rtl/sweep_stim_gen.sv
// sweep_stim_gen
//
// Stimulus source that sits directly upstream of the DUT input. It steps a
// signed fixed-point code from START towards STOP in increments of STEP,
// presenting one sample per accepted valid/ready handshake. Every sample
// also carries a copy of the code clamped to [CLIP_MIN, CLIP_MAX] and a
// zero-based sample index, so the downstream checker can form its expected
// value.
//
// Ports:
//   emu_clk    in   emulator clock, rising edge only
//   emu_rst_n  in   synchronous active-low reset
//   start      in   sweep request; sampled in IDLE and DONE only
//   out_ready  in   downstream accepts the current sample
//   out_valid  out  sample outputs are valid
//   in_code    out  signed swept code (WIDTH)
//   clip_code  out  in_code clamped to [CLIP_MIN, CLIP_MAX] (WIDTH)
//   idx        out  zero-based sample index, wraps modulo 2^CNT_W
//   busy       out  high while sweeping
//   done       out  sticky sweep-complete flag
//
// State  | meaning
// -------+------------------------------------------------------------
// IDLE   | after reset; waiting for start
// RUN    | presenting samples; advances on each handshake
// DONE   | sweep finished (or empty); done held until start or reset

module sweep_stim_gen #(
  parameter int WIDTH    = 16,
  parameter int START    = -15442,
  parameter int STOP     = 15442,
  parameter int STEP     = 205,
  parameter int CLIP_MIN = -12868,
  parameter int CLIP_MAX = 12868,
  parameter int CNT_W    = 10
) (
  input  logic                    emu_clk,
  input  logic                    emu_rst_n,
  input  logic                    start,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] in_code,
  output logic signed [WIDTH-1:0] clip_code,
  output logic [CNT_W-1:0]        idx,
  output logic                    busy,
  output logic                    done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // All comparisons are done one bit wider than the code so that the
  // stepped value can be tested for overflow before it is truncated.
  localparam logic signed [WIDTH:0] C_START_X = (WIDTH+1)'(START);
  localparam logic signed [WIDTH:0] C_STOP_X  = (WIDTH+1)'(STOP);
  localparam logic signed [WIDTH:0] C_STEP_X  = (WIDTH+1)'(STEP);
  localparam logic signed [WIDTH:0] C_CMIN_X  = (WIDTH+1)'(CLIP_MIN);
  localparam logic signed [WIDTH:0] C_CMAX_X  = (WIDTH+1)'(CLIP_MAX);
  localparam logic signed [WIDTH:0] C_MAX_X   = {2'b00, {(WIDTH-1){1'b1}}};
  localparam bit                    C_EMPTY   = (START > STOP);

  function automatic logic signed [WIDTH-1:0] f_clamp(input logic signed [WIDTH:0] x);
    logic signed [WIDTH:0] y;
    if (x < C_CMIN_X)
      y = C_CMIN_X;
    else if (x > C_CMAX_X)
      y = C_CMAX_X;
    else
      y = x;
    return y[WIDTH-1:0];
  endfunction

  logic [1:0]              r_state;
  logic                    r_valid;
  logic signed [WIDTH-1:0] r_in_code;
  logic signed [WIDTH-1:0] r_clip_code;
  logic [CNT_W-1:0]        r_idx;
  logic                    r_busy;
  logic                    r_done;

  logic signed [WIDTH:0]   w_nxt;
  logic                    w_last;
  logic signed [WIDTH-1:0] w_nxt_clip;
  logic signed [WIDTH-1:0] w_start_clip;

  assign w_nxt        = $signed({r_in_code[WIDTH-1], r_in_code}) + C_STEP_X;
  // The sweep ends when the next code would pass STOP or no longer fit.
  assign w_last       = (w_nxt > C_STOP_X) || (w_nxt > C_MAX_X);
  assign w_nxt_clip   = f_clamp(w_nxt);
  assign w_start_clip = f_clamp(C_START_X);

  always_ff @(posedge emu_clk) begin
    if (!emu_rst_n) begin
      r_state     <= S_IDLE;
      r_valid     <= 1'b0;
      r_in_code   <= '0;
      r_clip_code <= '0;
      r_idx       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (C_EMPTY) begin
              // Empty range: report completion without producing a sample.
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_RUN;
              r_valid     <= 1'b1;
              r_busy      <= 1'b1;
              r_done      <= 1'b0;
              r_in_code   <= C_START_X[WIDTH-1:0];
              r_clip_code <= w_start_clip;
              r_idx       <= '0;
            end
          end
        end
        S_RUN: begin
          if (out_ready) begin
            if (w_last) begin
              // Last sample accepted; data outputs keep the final sample.
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_in_code   <= w_nxt[WIDTH-1:0];
              r_clip_code <= w_nxt_clip;
              r_idx       <= r_idx + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_valid;
  assign in_code   = r_in_code;
  assign clip_code = r_clip_code;
  assign idx       = r_idx;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_sweep_stim_gen.sv
// Bench for sweep_stim_gen. Four instances cover the default sweep, a
// short sweep crossing the clip bound, an empty range and a sweep that
// stops on overflow. A per-cycle reference (sample k of n, code =
// START + k*STEP) is compared with every instance's outputs, and the
// directed tests pin key samples to hand-computed literals.

module tb_sweep_stim_gen;

  logic clk;
  logic rst_n [4];
  logic start_s [4];
  logic rdy [4];
  logic vld [4];
  logic bsy [4];
  logic dne [4];
  logic signed [15:0] inc [4];
  logic signed [15:0] clp [4];
  logic [9:0] idx [4];

  int n_cmp = 0;
  int n_bad = 0;

  int hs [4];
  int last_in [4];
  int last_clip [4];
  int last_idx [4];

  bit m_run [4];
  bit m_done [4];
  bit m_live [4];
  int m_k [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sweep_stim_gen u_def (
    .emu_clk(clk), .emu_rst_n(rst_n[0]), .start(start_s[0]), .out_ready(rdy[0]),
    .out_valid(vld[0]), .in_code(inc[0]), .clip_code(clp[0]), .idx(idx[0]),
    .busy(bsy[0]), .done(dne[0]));

  sweep_stim_gen #(.START(12800), .STOP(13000), .STEP(68)) u_clip (
    .emu_clk(clk), .emu_rst_n(rst_n[1]), .start(start_s[1]), .out_ready(rdy[1]),
    .out_valid(vld[1]), .in_code(inc[1]), .clip_code(clp[1]), .idx(idx[1]),
    .busy(bsy[1]), .done(dne[1]));

  sweep_stim_gen #(.START(100), .STOP(50)) u_empty (
    .emu_clk(clk), .emu_rst_n(rst_n[2]), .start(start_s[2]), .out_ready(rdy[2]),
    .out_valid(vld[2]), .in_code(inc[2]), .clip_code(clp[2]), .idx(idx[2]),
    .busy(bsy[2]), .done(dne[2]));

  sweep_stim_gen #(.START(32000), .STOP(32767), .STEP(1000)) u_ovf (
    .emu_clk(clk), .emu_rst_n(rst_n[3]), .start(start_s[3]), .out_ready(rdy[3]),
    .out_valid(vld[3]), .in_code(inc[3]), .clip_code(clp[3]), .idx(idx[3]),
    .busy(bsy[3]), .done(dne[3]));

  function automatic int p_start(int i);
    case (i)
      0: return -15442;
      1: return 12800;
      2: return 100;
      default: return 32000;
    endcase
  endfunction

  function automatic int p_stop(int i);
    case (i)
      0: return 15442;
      1: return 13000;
      2: return 50;
      default: return 32767;
    endcase
  endfunction

  function automatic int p_step(int i);
    case (i)
      1: return 68;
      3: return 1000;
      default: return 205;
    endcase
  endfunction

  // Number of samples a sweep produces, limited by both STOP and the
  // largest 16-bit signed code.
  function automatic int n_samples(int i);
    int n, nov;
    if (p_start(i) > p_stop(i)) return 0;
    n   = (p_stop(i) - p_start(i)) / p_step(i) + 1;
    nov = (32767 - p_start(i)) / p_step(i) + 1;
    return (nov < n) ? nov : n;
  endfunction

  function automatic int clamp(int x);
    if (x < -12868) return -12868;
    if (x > 12868) return 12868;
    return x;
  endfunction

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (vld[i] === 1'b1 && rdy[i] === 1'b1) begin
        hs[i]++;
        last_in[i]   = inc[i];
        last_clip[i] = clp[i];
        last_idx[i]  = idx[i];
      end
      if (!rst_n[i]) begin
        m_run[i] = 0; m_done[i] = 0; m_live[i] = 0; m_k[i] = 0;
      end else if (m_run[i]) begin
        if (rdy[i]) begin
          if (m_k[i] + 1 < n_samples(i)) m_k[i]++;
          else begin m_run[i] = 0; m_done[i] = 1; end
        end
      end else if (start_s[i]) begin
        if (n_samples(i) > 0) begin
          m_run[i] = 1; m_done[i] = 0; m_live[i] = 1; m_k[i] = 0;
        end else begin
          m_done[i] = 1;
        end
      end
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      int e_in;
      e_in = m_live[i] ? p_start(i) + m_k[i] * p_step(i) : 0;
      chk($sformatf("cyc_valid%0d", i), {31'd0, vld[i]}, {31'd0, m_run[i]});
      chk($sformatf("cyc_busy%0d", i), {31'd0, bsy[i]}, {31'd0, m_run[i]});
      chk($sformatf("cyc_done%0d", i), {31'd0, dne[i]}, {31'd0, m_done[i]});
      chk($sformatf("cyc_in%0d", i), inc[i], e_in);
      chk($sformatf("cyc_clip%0d", i), clp[i], m_live[i] ? clamp(e_in) : 0);
      chk($sformatf("cyc_idx%0d", i), {22'd0, idx[i]}, m_live[i] ? (m_k[i] % 1024) : 0);
    end
  end

  task automatic pulse_start(input int i);
    @(negedge clk) start_s[i] = 1'b1;
    @(negedge clk) start_s[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input string nm);
    int c = 0;
    while (dne[i] !== 1'b1 && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk(nm, {31'd0, dne[i]}, 1);
  endtask

  task automatic wait_idx(input int i, input int v, input string nm);
    int c = 0;
    while (idx[i] !== 10'(v) && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk(nm, {22'd0, idx[i]}, v);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst_n[i] = 1'b0; start_s[i] = 1'b0; rdy[i] = 1'b1;
      hs[i] = 0; last_in[i] = 0; last_clip[i] = 0; last_idx[i] = 0;
      m_run[i] = 0; m_done[i] = 0; m_live[i] = 0; m_k[i] = 0;
    end
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, vld[0]}, 0);
    chk("rst_in", inc[0], 0);
    chk("rst_idx", {22'd0, idx[0]}, 0);
    chk("rst_done", {31'd0, dne[0]}, 0);
    for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;

    // Full default sweep at full throughput.
    hs[0] = 0;
    pulse_start(0);
    chk("t1_first_in", inc[0], -15442);
    chk("t1_first_clip", clp[0], -12868);
    chk("t1_first_idx", {22'd0, idx[0]}, 0);
    chk("t1_first_valid", {31'd0, vld[0]}, 1);
    wait_done(0, "t1_done");
    chk("t1_count", hs[0], 151);
    chk("t1_last_in", last_in[0], 15308);
    chk("t1_last_clip", last_clip[0], 12868);
    chk("t1_last_idx", last_idx[0], 150);
    chk("t1_end_valid", {31'd0, vld[0]}, 0);

    // Restart from DONE with backpressure at idx 5.
    hs[0] = 0;
    pulse_start(0);
    chk("t2_done_cleared", {31'd0, dne[0]}, 0);
    wait_idx(0, 5, "t2_reach5");
    rdy[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t2_hold_in", inc[0], -14417);
      chk("t2_hold_clip", clp[0], -12868);
      chk("t2_hold_idx", {22'd0, idx[0]}, 5);
      chk("t2_hold_valid", {31'd0, vld[0]}, 1);
    end
    rdy[0] = 1'b1;
    @(negedge clk);
    chk("t2_idx6", {22'd0, idx[0]}, 6);
    wait_done(0, "t2_done");
    chk("t2_count", hs[0], 151);

    // start ignored mid-sweep, reset aborts, restart from scratch.
    pulse_start(0);
    wait_idx(0, 10, "t6_reach10");
    start_s[0] = 1'b1;
    @(negedge clk) start_s[0] = 1'b0;
    chk("t6_ign_idx", {22'd0, idx[0]}, 11);
    chk("t6_ign_busy", {31'd0, bsy[0]}, 1);
    wait_idx(0, 40, "t6_reach40");
    rst_n[0] = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", {31'd0, vld[0]}, 0);
    chk("t6_rst_in", inc[0], 0);
    chk("t6_rst_clip", clp[0], 0);
    chk("t6_rst_idx", {22'd0, idx[0]}, 0);
    chk("t6_rst_busy", {31'd0, bsy[0]}, 0);
    chk("t6_rst_done", {31'd0, dne[0]}, 0);
    rst_n[0] = 1'b1;
    hs[0] = 0;
    pulse_start(0);
    chk("t6_re_in", inc[0], -15442);
    chk("t6_re_idx", {22'd0, idx[0]}, 0);
    wait_done(0, "t6_done");
    chk("t6_count", hs[0], 151);

    // Short sweep crossing the upper clip bound.
    hs[1] = 0;
    pulse_start(1);
    chk("t3_s0_in", inc[1], 12800);
    chk("t3_s0_clip", clp[1], 12800);
    chk("t3_s0_idx", {22'd0, idx[1]}, 0);
    @(negedge clk);
    chk("t3_s1_in", inc[1], 12868);
    chk("t3_s1_clip", clp[1], 12868);
    chk("t3_s1_idx", {22'd0, idx[1]}, 1);
    @(negedge clk);
    chk("t3_s2_in", inc[1], 12936);
    chk("t3_s2_clip", clp[1], 12868);
    chk("t3_s2_idx", {22'd0, idx[1]}, 2);
    @(negedge clk);
    chk("t3_done", {31'd0, dne[1]}, 1);
    chk("t3_end_valid", {31'd0, vld[1]}, 0);
    chk("t3_count", hs[1], 3);

    // Empty range.
    hs[2] = 0;
    pulse_start(2);
    chk("t4_done", {31'd0, dne[2]}, 1);
    chk("t4_valid", {31'd0, vld[2]}, 0);
    chk("t4_busy", {31'd0, bsy[2]}, 0);
    repeat (3) @(negedge clk);
    chk("t4_count", hs[2], 0);

    // Overflow stops after one sample.
    hs[3] = 0;
    pulse_start(3);
    chk("t5_in", inc[3], 32000);
    chk("t5_valid", {31'd0, vld[3]}, 1);
    chk("t5_idx", {22'd0, idx[3]}, 0);
    @(negedge clk);
    chk("t5_done", {31'd0, dne[3]}, 1);
    chk("t5_end_valid", {31'd0, vld[3]}, 0);
    chk("t5_hold_in", inc[3], 32000);
    repeat (2) @(negedge clk);
    chk("t5_count", hs[3], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sweep_stim_gen.md
Name: sweep_stim_gen

Overview:
- Synthesizable emulator-side stimulus source for the function-model tests; sits directly upstream of the DUT input.
- Steps a signed fixed-point code from START to STOP by STEP, one sample per accepted handshake.
- Alongside each sample, emits a range-clipped copy of the code and a sample index, so the downstream checker can form its expected value.
- Replaces the per-cycle software sweep loop with hardware pacing under valid/ready flow control.

Parameters:
- WIDTH, 16, bit width of the signed fixed-point codes (LSB = 2^-12 in the default test setup).
- START, -15442, first code (about -1.2*pi).
- STOP, 15442, last permissible code, inclusive.
- STEP, 205, positive increment (about 0.05). STEP <= 0 is illegal.
- CLIP_MIN, -12868, lower clip bound for clip_code (about -pi).
- CLIP_MAX, 12868, upper clip bound for clip_code (about +pi). CLIP_MIN <= CLIP_MAX is required.
- CNT_W, 10, width of the sample index.

Ports:
- emu_clk, input, 1, emulator clock; all logic is on its rising edge.
- emu_rst_n, input, 1, synchronous active-low reset.
- start, input, 1, sweep request; sampled in IDLE and DONE only.
- out_ready, input, 1, downstream accepts the current sample.
- out_valid, output, 1, sample outputs are valid.
- in_code, output, WIDTH, signed swept stimulus code.
- clip_code, output, WIDTH, signed in_code clamped to [CLIP_MIN, CLIP_MAX].
- idx, output, CNT_W, zero-based sample index.
- busy, output, 1, high while in RUN.
- done, output, 1, sticky sweep-complete flag.

Behaviour:
- Reset (emu_rst_n = 0 at an edge): state IDLE; out_valid, in_code, clip_code, idx, busy and done are all 0. Reset dominates every other input, including mid-sweep (the sweep is aborted).
- All outputs are registered.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start = 1:
  - If START <= STOP: next state RUN; in_code = START, clip_code = clamp(START), idx = 0, out_valid = 1, busy = 1, done = 0. Outputs are visible the cycle after start is sampled.
  - If START > STOP: next state DONE with done = 1; out_valid never asserts (zero samples).
- RUN, out_valid & out_ready (handshake):
  - Compute nxt = in_code + STEP at WIDTH+1 bits, signed.
  - If nxt > STOP, or nxt exceeds the maximum WIDTH-bit signed value: next state DONE; out_valid = 0, busy = 0, done = 1. in_code, clip_code and idx hold their last values.
  - Otherwise: in_code = nxt, clip_code = clamp(nxt), idx = idx + 1 (wraps modulo 2^CNT_W).
- RUN with out_valid & !out_ready: all outputs hold unchanged; out_valid stays 1 (no drop, no skip).
- start in RUN is ignored.
- done stays 1 in DONE until the next start or reset.
- Sample count = floor((STOP - START)/STEP) + 1 when START <= STOP and no overflow occurs.
- clamp(x) = CLIP_MIN if x < CLIP_MIN; CLIP_MAX if x > CLIP_MAX; else x. Bounds are inclusive, so x == bound passes through unchanged.
- Throughput: one sample per cycle with out_ready held high.

Test Plan:
1. Defaults, reset then 1-cycle start pulse, out_ready = 1 -> 151 handshakes.
   - First sample: in_code = -15442, clip_code = -12868, idx = 0.
   - Last sample: in_code = 15308, clip_code = 12868, idx = 150.
   - done = 1 and out_valid = 0 the cycle after the last handshake.
2. Defaults, out_ready = 0 for 3 cycles while idx = 5 -> in_code = -14417, clip_code = -12868, idx = 5 held for all 3 cycles with out_valid = 1. idx = 6 follows the next accepted cycle; total sample count is still 151.
3. START = 12800, STEP = 68, STOP = 13000 -> exactly 3 samples:
   - (12800, 12800, 0)
   - (12868, 12868, 1)
   - (12936, 12868, 2)
   - then done.
4. START = 100, STOP = 50 with start pulse -> DONE and done = 1 one cycle later; out_valid stays 0 throughout.
5. START = 32000, STEP = 1000, STOP = 32767 -> single sample in_code = 32000, then done. The overflowing next value 33000 is never output.
6. Reset and start interactions on defaults:
   - start re-pulsed at idx = 10 -> ignored, sweep continues normally.
   - emu_rst_n = 0 at idx = 40 -> all outputs 0 and state IDLE the next cycle.
   - A new start restarts at in_code = -15442, idx = 0.
   - start after DONE clears done and reruns all 151 samples.
